// File: rtl/mem_stream_reader.sv
// Streams `len` consecutive words from an async-read memory onto a valid/ready port.
// Optional feature macro: MEM_STREAM_LOOP_EN (adds `loop` input for repeated passes).
module mem_stream_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef MEM_STREAM_LOOP_EN
    input  logic                  loop,
`endif
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);
    // Handshake: a word transfers on a posedge where m_valid & m_ready; while
    // m_valid=1 and m_ready=0, m_data/m_last hold and m_valid stays high.

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  load;

`ifdef MEM_STREAM_LOOP_EN
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  loop_q;
`endif

    // Output register is refilled when empty or when its word is leaving.
    assign load = !m_valid || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            read_addr <= '0;
            remaining <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MEM_STREAM_LOOP_EN
            base_q    <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        read_addr <= base_addr;
                        remaining <= len;
                        busy      <= 1'b1;
`ifdef MEM_STREAM_LOOP_EN
                        base_q    <= base_addr;
                        len_q     <= len;
                        loop_q    <= loop;
`endif
                        state     <= (len != '0) ? S_RUN : S_FIN;
                    end
                end
                S_RUN: begin
                    if (load) begin
                        m_data    <= read_data;
                        m_valid   <= 1'b1;
                        read_addr <= read_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH + 1)'(1);
                        if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                            m_last <= 1'b1;
                            state  <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        state   <= S_FIN;
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
`ifdef MEM_STREAM_LOOP_EN
                    // Another pass only while both the captured and live loop bits agree.
                    if (loop_q && loop) begin
                        read_addr <= base_q;
                        remaining <= len_q;
                        state     <= (len_q != '0) ? S_RUN : S_FIN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: memory array model, block driver, and per-scenario checks.
module tb_mem_stream_reader;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;
`ifdef MEM_STREAM_LOOP_EN
    logic          loop;
`endif

    logic [DW-1:0] mem [DEPTH];
    assign read_data = mem[read_addr];

    mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef MEM_STREAM_LOOP_EN
        .loop      (loop),
`endif
        .read_addr (read_addr),
        .read_data (read_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Scoreboard and observations of the most recent block
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_data[$];
    logic          obs_last[$];
    logic [AW-1:0] obs_raddr[$];
    int            obs_cycle[$];
    int first_valid_cyc, done_cyc, done_count, busy_low_early, busy_after, unstable, timed_out;

    task automatic preload_ramp;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0100 + DW'(i);
    endtask

    task automatic build_expected(input int base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
    endtask

    // Starts one block and records every transfer; inputs change on negedge.
    task automatic drive_block(input int base, input int n, input int ready_mode,
                               input int restart_at, input int max_cycles);
        logic          prev_hold;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        obs_data.delete(); obs_last.delete(); obs_raddr.delete(); obs_cycle.delete();
        first_valid_cyc = -1; done_cyc = -1; done_count = 0;
        busy_low_early = 0; busy_after = 0; unstable = 0; timed_out = 0;
        prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;
        @(negedge clk);
        base_addr = base[AW-1:0];
        len       = n[AW:0];
        start     = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (start) begin
                base_addr = AW'($urandom_range(0, DEPTH - 1));
                len       = (AW + 1)'($urandom_range(1, DEPTH));
            end
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (c % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_hold && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                unstable++;
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (m_valid && m_ready) begin
                obs_data.push_back(m_data);
                obs_last.push_back(m_last);
                obs_raddr.push_back(read_addr);
                obs_cycle.push_back(c);
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc < 0 && !busy) busy_low_early++;
            if (done_cyc >= 0 && busy) busy_after++;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        if (done_cyc < 0) timed_out = 1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        logic [DW+AW+4:0] got;
        rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; base_addr = '0; len = '0;
        repeat (2) @(negedge clk);
        got = {m_valid, m_data, m_last, busy, done, read_addr};
        vectors++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", got);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [DW+AW:0] got, want;
        preload_ramp();
        build_expected(2, 4);
        drive_block(2, 4, 0, -1, 40);
        vectors++;
        if (obs_data.size() != 4 || timed_out != 0) begin
            errors++;
            $display("FAIL basic_count: got %0d words (timeout=%0d), expected 4", obs_data.size(), timed_out);
        end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            got  = {obs_data[i], obs_last[i], obs_raddr[i]};
            want = {exp_q[i], 1'(i == 3), AW'((2 + i + 1) % DEPTH)};
            vectors++;
            if (got !== want || obs_cycle[i] != i + 1) begin
                errors++;
                $display("FAIL basic_word%0d: got %h at cycle %0d, expected %h at cycle %0d",
                         i, got, obs_cycle[i], want, i + 1);
            end
        end
        vectors++;
        if (first_valid_cyc != 1 || done_cyc != 6 || done_count != 1 || busy_low_early != 0) begin
            errors++;
            $display("FAIL basic_timing: first_valid=%0d done=%0d count=%0d busy_low=%0d, expected 1 6 1 0",
                     first_valid_cyc, done_cyc, done_count, busy_low_early);
        end
    endtask

    task automatic test_wrap;
        logic [DW+AW:0] got, want;
        preload_ramp();
        build_expected(14, 4);
        drive_block(14, 4, 0, -1, 40);
        vectors++;
        if (obs_data.size() != 4 || timed_out != 0) begin
            errors++;
            $display("FAIL wrap_count: got %0d words (timeout=%0d), expected 4", obs_data.size(), timed_out);
        end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            got  = {obs_data[i], obs_last[i], obs_raddr[i]};
            want = {exp_q[i], 1'(i == 3), AW'((14 + i + 1) % DEPTH)};
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h, expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [DW:0] got, want;
        preload_ramp();
        build_expected(2, 4);
        drive_block(2, 4, 1, -1, 60);
        vectors++;
        if (obs_data.size() != 4 || timed_out != 0 || unstable != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d words timeout=%0d unstable=%0d, expected 4 0 0",
                     obs_data.size(), timed_out, unstable);
        end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            got  = {obs_data[i], obs_last[i]};
            want = {exp_q[i], 1'(i == 3)};
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL bp_word%0d: got %h, expected %h", i, got, want);
            end
        end
        if (obs_cycle.size() > 0) begin
            vectors++;
            if (done_cyc != obs_cycle[obs_cycle.size() - 1] + 2) begin
                errors++;
                $display("FAIL bp_done: got cycle %0d, expected %0d", done_cyc, obs_cycle[obs_cycle.size() - 1] + 2);
            end
        end
    endtask

    task automatic test_zero_and_full;
        int base;
        preload_ramp();
        // len=0, with a start attempt landing in the FIN cycle
        drive_block(5, 0, 0, 0, 20);
        vectors++;
        if (obs_data.size() != 0 || first_valid_cyc != -1 || done_cyc != 1 || done_count != 1 ||
            busy_low_early != 0 || busy_after != 0) begin
            errors++;
            $display("FAIL zero_len: words=%0d valid_at=%0d done=%0d count=%0d busy_low=%0d busy_after=%0d, expected 0 -1 1 1 0 0",
                     obs_data.size(), first_valid_cyc, done_cyc, done_count, busy_low_early, busy_after);
        end
        base = $urandom_range(1, DEPTH - 1);
        build_expected(base, DEPTH);
        drive_block(base, DEPTH, 0, -1, 60);
        vectors++;
        if (obs_data.size() != DEPTH || done_cyc != DEPTH + 2) begin
            errors++;
            $display("FAIL full_count: got %0d words done=%0d, expected %0d done=%0d",
                     obs_data.size(), done_cyc, DEPTH, DEPTH + 2);
        end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_data[i] !== exp_q[i] || obs_last[i] !== 1'(i == DEPTH - 1)) begin
                errors++;
                $display("FAIL full_word%0d: got %h last=%0d, expected %h last=%0d",
                         i, obs_data[i], obs_last[i], exp_q[i], (i == DEPTH - 1));
            end
        end
    endtask

    task automatic test_restart_ignored;
        preload_ramp();
        build_expected(2, 4);
        drive_block(2, 4, 0, 1, 40);
        vectors++;
        if (obs_data.size() != 4 || done_count != 1 || busy_after != 0) begin
            errors++;
            $display("FAIL restart_count: got %0d words %0d dones busy_after=%0d, expected 4 1 0",
                     obs_data.size(), done_count, busy_after);
        end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_data[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_word%0d: got %h, expected %h", i, obs_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int xfers = 0;
        int bad = 0;
        logic [DW+AW+4:0] got;
        preload_ramp();
        m_ready = 1'b1;
        @(negedge clk);
        base_addr = 4'd2; len = 5'd4; start = 1'b1;
        for (int c = 0; c < 20 && xfers < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid && m_ready) xfers++;
        end
        vectors++;
        if (xfers != 2) begin
            errors++;
            $display("FAIL midreset_wait: got %0d transfers, expected 2", xfers);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        got = {m_valid, m_data, m_last, busy, done, read_addr};
        vectors++;
        if (got !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h, expected 0", got);
        end
        repeat (3) begin
            @(negedge clk);
            if (done || m_valid || busy) bad++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || m_valid || busy) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_quiet: got %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_random;
        int base, n;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            base = $urandom_range(0, DEPTH - 1);
            n    = $urandom_range(1, DEPTH);
            build_expected(base, n);
            drive_block(base, n, 2, -1, 400);
            vectors++;
            if (obs_data.size() != n || timed_out != 0 || unstable != 0 || done_count != 1) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d words timeout=%0d unstable=%0d dones=%0d, expected %0d 0 0 1",
                         t, obs_data.size(), timed_out, unstable, done_count, n);
            end
            for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
                vectors++;
                if (obs_data[i] !== exp_q[i] || obs_last[i] !== 1'(i == n - 1) ||
                    obs_raddr[i] !== AW'((base + i + 1) % DEPTH)) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: got %h last=%0d addr=%0d, expected %h last=%0d addr=%0d",
                             t, i, obs_data[i], obs_last[i], obs_raddr[i], exp_q[i], (i == n - 1),
                             (base + i + 1) % DEPTH);
                end
            end
        end
    endtask

`ifdef MEM_STREAM_LOOP_EN
    task automatic test_loop;
        int dones = 0;
        int words = 0;
        int idle_seen = 0;
        preload_ramp();
        m_ready = 1'b1;
        @(negedge clk);
        base_addr = '0; len = 5'd2; loop = 1'b1; start = 1'b1;
        for (int c = 0; c < 100 && idle_seen == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid && m_ready) begin
                vectors++;
                if (m_data !== mem[words % 2] || m_last !== 1'(words % 2 == 1)) begin
                    errors++;
                    $display("FAIL loop_word%0d: got %h last=%0d, expected %h last=%0d",
                             words, m_data, m_last, mem[words % 2], (words % 2 == 1));
                end
                words++;
            end
            if (done) begin
                dones++;
                if (dones == 3) loop = 1'b0;
            end
            if (dones > 0 && !busy) idle_seen = 1;
        end
        vectors++;
        if (words != 8 || dones != 4 || idle_seen != 1) begin
            errors++;
            $display("FAIL loop_passes: got %0d words %0d dones idle=%0d, expected 8 4 1", words, dones, idle_seen);
        end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
`ifdef MEM_STREAM_LOOP_EN
        loop = 1'b0;
`endif
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_full();
        test_restart_ignored();
        test_reset_mid();
        test_random();
`ifdef MEM_STREAM_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 400000");
        $fatal(1, "watchdog expired");
    end

endmodule
